// File: rtl/prf_rename_mw.sv
// prf_rename_mw: multi-lane register rename unit with a physical register file.
// Allocates NUM_ALLOC physical destinations per group, bypasses dependencies
// inside the group, keeps RAT checkpoints for single-cycle branch recovery and
// stores register data with write-to-read forwarding.
module prf_rename_mw #(
    parameter int NUM_ENTRIES    = 64,
    parameter int NUM_REGS       = 32,
    parameter int NUM_ALLOC      = 2,
    parameter int NUM_REG_READS  = 4,
    parameter int NUM_REG_WRITES = 2,
    parameter int NUM_RECLAIM    = 2,
    parameter int NUM_CKPT       = 4,
    parameter int PTYPE_W        = 2,
    parameter int DATA_W         = 64,
    localparam int PRF_W         = $clog2(NUM_ENTRIES),
    localparam int GPR_W         = $clog2(NUM_REGS),
    localparam int CKPT_W        = $clog2(NUM_CKPT),
    localparam int NUM_SRC       = 2 * NUM_ALLOC,
    localparam int PKT_W         = PTYPE_W + PRF_W + DATA_W
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [PTYPE_W-1:0]                prf_type,
    input  logic [NUM_ALLOC-1:0]              rn_vld_rn0,
    input  logic [NUM_ALLOC*GPR_W-1:0]        rn_gpr_rn0,
    input  logic [NUM_SRC*GPR_W-1:0]          rdmap_gpr_rn0,
    output logic                              rename_ready_rn0,
    output logic [NUM_ALLOC*PRF_W-1:0]        pdst_rn1,
    output logic [NUM_ALLOC*PRF_W-1:0]        pdst_old_rn1,
    output logic [NUM_SRC*PRF_W-1:0]          rdmap_psrc_rd1,
    output logic [NUM_SRC-1:0]                rdmap_pend_rd1,
    input  logic                              ckpt_take_rn0,
    input  logic [CKPT_W-1:0]                 ckpt_id_rn0,
    input  logic                              ckpt_rst_vld,
    input  logic [CKPT_W-1:0]                 ckpt_rst_id,
    input  logic                              ckpt_free,
    input  logic [CKPT_W-1:0]                 ckpt_free_id,
    input  logic [NUM_RECLAIM-1:0]            reclaim_vld,
    input  logic [NUM_RECLAIM*PRF_W-1:0]      reclaim_prfid,
    input  logic [NUM_RECLAIM*PTYPE_W-1:0]    reclaim_ptype,
    input  logic [NUM_REG_WRITES-1:0]         wr_en_nq_ro0,
    input  logic [NUM_REG_WRITES*PKT_W-1:0]   wr_pkt_ro0,
    input  logic [NUM_REG_READS*PRF_W-1:0]    rd_psrc_rd0,
    output logic [NUM_REG_READS*DATA_W-1:0]   rd_data_rd1
);

    localparam int CNT_W = PRF_W + 1;

    // architectural state
    logic [PRF_W-1:0]       map_q [NUM_REGS];
    logic [PRF_W-1:0]       map_d [NUM_REGS];
    logic [NUM_ENTRIES-1:0] free_q, free_d;
    logic [NUM_ENTRIES-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_d [NUM_ENTRIES];

    // checkpoint state; ckpt_after_q[i][j] marks j as taken after i
    logic [NUM_CKPT-1:0]    ckpt_vld_q, ckpt_vld_d;
    logic [PRF_W-1:0]       ckpt_map_q [NUM_CKPT][NUM_REGS];
    logic [PRF_W-1:0]       ckpt_map_d [NUM_CKPT][NUM_REGS];
    logic [NUM_ENTRIES-1:0] ckpt_mask_q [NUM_CKPT];
    logic [NUM_ENTRIES-1:0] ckpt_mask_d [NUM_CKPT];
    logic [NUM_CKPT-1:0]    ckpt_after_q [NUM_CKPT];
    logic [NUM_CKPT-1:0]    ckpt_after_d [NUM_CKPT];

    // registered outputs
    logic [NUM_ALLOC*PRF_W-1:0]      pdst_q, pdst_d;
    logic [NUM_ALLOC*PRF_W-1:0]      pdst_old_q, pdst_old_d;
    logic [NUM_SRC*PRF_W-1:0]        psrc_q, psrc_d;
    logic [NUM_SRC-1:0]              psrc_pend_q, psrc_pend_d;
    logic [NUM_REG_READS*DATA_W-1:0] rd_data_q, rd_data_d;

    // combinational helpers
    logic [CNT_W-1:0]       free_cnt;
    logic [NUM_ENTRIES-1:0] avail;
    logic [NUM_ENTRIES-1:0] alloc_bits;
    logic [NUM_ENTRIES-1:0] wr_clr;
    logic [NUM_ENTRIES-1:0] reclaim_bits;
    logic                   found;
    logic                   rst_ok;
    logic [NUM_ALLOC-1:0]   lane_alloc;
    logic [GPR_W-1:0]       lane_gpr [NUM_ALLOC];
    logic [PRF_W-1:0]       lane_pdst [NUM_ALLOC];
    logic [PRF_W-1:0]       lane_old [NUM_ALLOC];
    logic [GPR_W-1:0]       src_gpr [NUM_SRC];
    logic [PRF_W-1:0]       src_psrc [NUM_SRC];
    logic                   src_pend [NUM_SRC];
    logic [PTYPE_W-1:0]     wr_type [NUM_REG_WRITES];
    logic [PRF_W-1:0]       wr_idx [NUM_REG_WRITES];
    logic [DATA_W-1:0]      wr_data [NUM_REG_WRITES];
    logic [NUM_REG_WRITES-1:0] wr_hit;
    logic [PRF_W-1:0]       rd_idx [NUM_REG_READS];

    // readiness check and lowest-free-index allocation across valid lanes
    always_comb begin
        free_cnt = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            free_cnt = free_cnt + CNT_W'(free_q[e]);
        end
        rename_ready_rn0 = (free_cnt >= CNT_W'(NUM_ALLOC)) && !ckpt_rst_vld;
        avail      = free_q;
        alloc_bits = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            lane_gpr[k]   = rn_gpr_rn0[k*GPR_W +: GPR_W];
            lane_alloc[k] = rn_vld_rn0[k] && rename_ready_rn0;
            lane_pdst[k]  = '0;
            found         = 1'b0;
            if (lane_alloc[k]) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (!found && avail[e]) begin
                        lane_pdst[k] = PRF_W'(e);
                        avail[e]     = 1'b0;
                        found        = 1'b1;
                    end
                end
                alloc_bits[lane_pdst[k]] = 1'b1;
            end
        end
    end

    // unpack write-back packets and read addresses
    always_comb begin
        for (int w = 0; w < NUM_REG_WRITES; w++) begin
            wr_data[w] = wr_pkt_ro0[w*PKT_W +: DATA_W];
            wr_idx[w]  = wr_pkt_ro0[w*PKT_W + DATA_W +: PRF_W];
            wr_type[w] = wr_pkt_ro0[w*PKT_W + DATA_W + PRF_W +: PTYPE_W];
            wr_hit[w]  = wr_en_nq_ro0[w] && (wr_type[w] == prf_type);
        end
        for (int r = 0; r < NUM_REG_READS; r++) begin
            rd_idx[r] = rd_psrc_rd0[r*PRF_W +: PRF_W];
        end
    end

    // next map, free list, pending list and checkpoint state
    always_comb begin
        rst_ok       = ckpt_rst_vld && ckpt_vld_q[ckpt_rst_id];
        wr_clr       = '0;
        reclaim_bits = '0;
        for (int w = 0; w < NUM_REG_WRITES; w++) begin
            if (wr_hit[w]) wr_clr[wr_idx[w]] = 1'b1;
        end
        for (int r = 0; r < NUM_RECLAIM; r++) begin
            if (reclaim_vld[r] && (reclaim_ptype[r*PTYPE_W +: PTYPE_W] == prf_type)) begin
                reclaim_bits[reclaim_prfid[r*PRF_W +: PRF_W]] = 1'b1;
            end
        end

        map_d = map_q;
        if (rst_ok) begin
            for (int g = 0; g < NUM_REGS; g++) map_d[g] = ckpt_map_q[ckpt_rst_id][g];
        end else begin
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if (lane_alloc[k]) map_d[lane_gpr[k]] = lane_pdst[k];
            end
        end

        pend_d = (pend_q & ~wr_clr) | alloc_bits;
        free_d = (free_q & ~alloc_bits) | reclaim_bits;
        if (rst_ok) begin
            pend_d = pend_d & ~ckpt_mask_q[ckpt_rst_id];
            free_d = free_d | ckpt_mask_q[ckpt_rst_id];
        end

        ckpt_vld_d   = ckpt_vld_q;
        ckpt_map_d   = ckpt_map_q;
        ckpt_after_d = ckpt_after_q;
        for (int i = 0; i < NUM_CKPT; i++) begin
            ckpt_mask_d[i] = ckpt_vld_q[i] ? (ckpt_mask_q[i] | alloc_bits) : ckpt_mask_q[i];
        end
        if (ckpt_free) ckpt_vld_d[ckpt_free_id] = 1'b0;
        if (rst_ok) begin
            ckpt_mask_d[ckpt_rst_id]  = '0;
            ckpt_after_d[ckpt_rst_id] = '0;
            for (int j = 0; j < NUM_CKPT; j++) begin
                if (ckpt_after_q[ckpt_rst_id][j]) ckpt_vld_d[j] = 1'b0;
            end
        end else if (ckpt_take_rn0) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (ckpt_vld_d[i] && (i != int'(ckpt_id_rn0))) ckpt_after_d[i][ckpt_id_rn0] = 1'b1;
            end
            ckpt_vld_d[ckpt_id_rn0]   = 1'b1;
            ckpt_mask_d[ckpt_id_rn0]  = '0;
            ckpt_after_d[ckpt_id_rn0] = '0;
            for (int g = 0; g < NUM_REGS; g++) ckpt_map_d[ckpt_id_rn0][g] = map_d[g];
        end
    end

    // previous mappings and source lookups with intra-group bypass
    always_comb begin
        pdst_d      = '0;
        pdst_old_d  = '0;
        psrc_d      = '0;
        psrc_pend_d = '0;
        for (int j = 0; j < NUM_ALLOC; j++) begin
            lane_old[j] = map_q[lane_gpr[j]];
            for (int i = 0; i < j; i++) begin
                if (lane_alloc[i] && (lane_gpr[i] == lane_gpr[j])) lane_old[j] = lane_pdst[i];
            end
            if (lane_alloc[j]) begin
                pdst_d[j*PRF_W +: PRF_W]     = lane_pdst[j];
                pdst_old_d[j*PRF_W +: PRF_W] = lane_old[j];
            end
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            src_gpr[s]  = rdmap_gpr_rn0[s*GPR_W +: GPR_W];
            src_psrc[s] = map_q[src_gpr[s]];
            src_pend[s] = pend_d[map_q[src_gpr[s]]];
            for (int i = 0; i < s / 2; i++) begin
                if (lane_alloc[i] && (lane_gpr[i] == src_gpr[s])) begin
                    src_psrc[s] = lane_pdst[i];
                    src_pend[s] = 1'b1;
                end
            end
            psrc_d[s*PRF_W +: PRF_W] = src_psrc[s];
            psrc_pend_d[s]           = src_pend[s];
        end
    end

    // register file write and read with same-cycle write forwarding
    always_comb begin
        data_d = data_q;
        for (int w = 0; w < NUM_REG_WRITES; w++) begin
            if (wr_hit[w]) data_d[wr_idx[w]] = wr_data[w];
        end
        rd_data_d = '0;
        for (int r = 0; r < NUM_REG_READS; r++) begin
            rd_data_d[r*DATA_W +: DATA_W] = data_q[rd_idx[r]];
            for (int w = 0; w < NUM_REG_WRITES; w++) begin
                if (wr_hit[w] && (wr_idx[w] == rd_idx[r])) rd_data_d[r*DATA_W +: DATA_W] = wr_data[w];
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < NUM_REGS; g++) map_q[g] <= PRF_W'(g);
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                free_q[e] <= (e >= NUM_REGS);
                data_q[e] <= '0;
            end
            pend_q     <= '0;
            ckpt_vld_q <= '0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_mask_q[i]  <= '0;
                ckpt_after_q[i] <= '0;
                for (int g = 0; g < NUM_REGS; g++) ckpt_map_q[i][g] <= '0;
            end
            pdst_q      <= '0;
            pdst_old_q  <= '0;
            psrc_q      <= '0;
            psrc_pend_q <= '0;
            rd_data_q   <= '0;
        end else begin
            map_q        <= map_d;
            free_q       <= free_d;
            pend_q       <= pend_d;
            data_q       <= data_d;
            ckpt_vld_q   <= ckpt_vld_d;
            ckpt_map_q   <= ckpt_map_d;
            ckpt_mask_q  <= ckpt_mask_d;
            ckpt_after_q <= ckpt_after_d;
            pdst_q       <= pdst_d;
            pdst_old_q   <= pdst_old_d;
            psrc_q       <= psrc_d;
            psrc_pend_q  <= psrc_pend_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign pdst_rn1       = pdst_q;
    assign pdst_old_rn1   = pdst_old_q;
    assign rdmap_psrc_rd1 = psrc_q;
    assign rdmap_pend_rd1 = psrc_pend_q;
    assign rd_data_rd1    = rd_data_q;

    // illegal usage: renaming while not ready, restoring a dead checkpoint, double free
    a_rename_when_ready: assert property (@(posedge clk) disable iff (!reset_n)
        !(|rn_vld_rn0 && !rename_ready_rn0));
    a_restore_valid: assert property (@(posedge clk) disable iff (!reset_n)
        !(ckpt_rst_vld && !ckpt_vld_q[ckpt_rst_id]));
    a_reclaim_busy: assert property (@(posedge clk) disable iff (!reset_n)
        !(|(reclaim_bits & free_q)));

endmodule
